// File: rtl/vga_framebuffer_if.sv
// Pixel-plot bus between the drawing engine and the framebuffer.
//   x, y    : logical pixel coordinate (valid 0..159 / 0..119)
//   colour  : {R,G,B}
//   plot    : write strobe, one pixel per cycle while high
//   ready   : framebuffer has finished its power-on clear and accepts plots
interface vga_framebuffer_if;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       ready;

    modport master (output x, y, colour, plot, input ready);
    modport slave  (input x, y, colour, plot, output ready);
endinterface

// File: rtl/vga_framebuffer.sv
// 160x120x3 framebuffer with a VGA scan-out (4x4 pixel replication).
// Ports:
//   clk, reset  : single clock, synchronous active-high reset
//   pix         : plot bus (slave side), ready = clear done
//   VGA_CLK     : pixel clock, clk/2
//   VGA_HS/VS   : active-low syncs
//   VGA_BLANK_N : high in the visible region
//   VGA_SYNC_N  : tied 0
//   VGA_R/G/B   : colour bits replicated to 10 bits, 0 when blanked or not ready
// Scan pipeline: counters -> address + memory read -> registered outputs,
// so every VGA output lags the counters by 2 clk.
module vga_framebuffer #(
    parameter logic [2:0] BACKGROUND = 3'b000,
    parameter int H_VIS = 640, H_FP = 16, H_SYNC = 96, H_BP = 48,
    parameter int V_VIS = 480, V_FP = 10, V_SYNC = 2,  V_BP = 33
) (
    input  logic             clk,
    input  logic             reset,
    vga_framebuffer_if.slave pix,
    output logic             VGA_CLK,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_BLANK_N,
    output logic             VGA_SYNC_N,
    output logic [9:0]       VGA_R,
    output logic [9:0]       VGA_G,
    output logic [9:0]       VGA_B
);
    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int STAGES   = 2;

    localparam logic [14:0] CLR_LAST = 15'(FB_DEPTH - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0]  V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0]  HS_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0]  HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  VS_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_VIS + V_FP + V_SYNC);

    typedef enum logic {CLEAR, RUN} state_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic rdy;
    } scan_t;

    localparam scan_t SCAN_IDLE = '{hs: 1'b1, vs: 1'b1, rdy: 1'b0};

    logic [2:0] mem [0:FB_DEPTH-1];

    // ---------------- write side ----------------
    state_t      state, state_nx;
    logic [14:0] clr_addr, clr_addr_nx;
    logic        we;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;
    logic [14:0] plot_row, plot_addr;
    logic        in_range;
    logic        ready;

    // y*160 + x without a multiplier
    assign plot_row  = 15'(pix.y);
    assign plot_addr = (plot_row << 7) + (plot_row << 5) + 15'(pix.x);
    assign in_range  = (pix.x < 10'(FB_W)) && (pix.y < 10'(FB_H));
    assign ready     = (state == RUN);
    assign pix.ready = ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nx;
            clr_addr <= clr_addr_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        clr_addr_nx = clr_addr;
        we          = 1'b0;
        wr_addr     = plot_addr;
        wr_data     = pix.colour;
        case (state)
            CLEAR: begin
                we      = 1'b1;
                wr_addr = clr_addr;
                wr_data = BACKGROUND;
                if (clr_addr == CLR_LAST) begin
                    state_nx    = RUN;
                    clr_addr_nx = '0;
                end else begin
                    clr_addr_nx = clr_addr + 15'd1;
                end
            end
            RUN: we = pix.plot && in_range;
            default: state_nx = CLEAR;
        endcase
    end

    // The reset edge itself must not land a stale plot in the buffer.
    always_ff @(posedge clk) begin
        if (we && !reset)
            mem[wr_addr] <= wr_data;
    end

    // ---------------- scan side, stage 0: counters ----------------
    logic       pix_en;
    logic [9:0] hcount, vcount;

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_en <= 1'b0;
            hcount <= '0;
            vcount <= '0;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                if (hcount == H_LAST) begin
                    hcount <= '0;
                    vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
                end else begin
                    hcount <= hcount + 10'd1;
                end
            end
        end
    end

    logic        visible, hs0, vs0;
    logic [14:0] scan_row, rd_addr;

    assign visible  = (hcount < H_VIS_C) && (vcount < V_VIS_C);
    assign hs0      = !((hcount >= HS_BEG) && (hcount < HS_END));
    assign vs0      = !((vcount >= VS_BEG) && (vcount < VS_END));
    assign scan_row = 15'(vcount >> 2);
    // Parked at 0 outside the visible area so the address never leaves the array.
    assign rd_addr  = visible ? (scan_row << 7) + (scan_row << 5) + 15'(hcount >> 2) : '0;

    // ---------------- stage 1: memory read ----------------
    // Same-address collisions return the pre-write contents.
    logic [2:0] rd_data;
    always_ff @(posedge clk) rd_data <= mem[rd_addr];

    // ---------------- stage 1/2 control + registered outputs ----------------
    logic [STAGES:1] vld_pipe;
    scan_t           s1;
    logic            hs_q, vs_q;
    logic [2:0]      rgb;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            s1       <= SCAN_IDLE;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            rgb      <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], visible};
            s1       <= '{hs: hs0, vs: vs0, rdy: ready};
            hs_q     <= s1.hs;
            vs_q     <= s1.vs;
            rgb      <= (vld_pipe[1] && s1.rdy) ? rd_data : 3'b000;
        end
    end

    assign VGA_CLK     = pix_en;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = vld_pipe[STAGES];
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = {10{rgb[2]}};
    assign VGA_G       = {10{rgb[1]}};
    assign VGA_B       = {10{rgb[0]}};
endmodule

// File: tb/tb_vga_framebuffer.sv
// Randomized bench for vga_framebuffer with shortened sync timing so whole
// frames fit in the run. The reference model derives every output from the
// number of clock edges since reset and a plain array image of the buffer.
module tb_vga_framebuffer;
    localparam int HV = 64, HF = 4, HSY = 8, HB = 4, HT = HV + HF + HSY + HB;
    localparam int VV = 48, VF = 2, VSY = 2, VB = 3, VT = VV + VF + VSY + VB;
    localparam int CLR = 19200;
    localparam int FRAME = 2 * HT * VT;

    logic clk = 1'b0;
    logic reset;
    logic VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic [9:0] VGA_R, VGA_G, VGA_B;

    always #10 clk = ~clk;

    vga_framebuffer_if pix();

    vga_framebuffer #(
        .BACKGROUND(3'b000),
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
    ) dut (
        .clk(clk), .reset(reset), .pix(pix),
        .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit         v;
        int         a;
        logic [2:0] c;
    } wr_t;

    logic [2:0] fb [0:CLR-1];
    int  k = -1;          // edges since the reset edge; -1 = never reset
    wr_t d1, d2;          // accepted plots become visible in the output 2 edges later

    task automatic check_outputs();
        int t, h, v;
        logic hs, vs, bl;
        logic [2:0] c;
        if (k < 0) return;
        if (k < 2) begin
            hs = 1'b1; vs = 1'b1; bl = 1'b0; c = 3'b000;
        end else begin
            t  = (k - 2) / 2;
            h  = t % HT;
            v  = (t / HT) % VT;
            bl = (h < HV) && (v < VV);
            hs = !((h >= HV + HF) && (h < HV + HF + HSY));
            vs = !((v >= VV + VF) && (v < VV + VF + VSY));
            c  = (bl && (k - 2 >= CLR)) ? fb[(v / 4) * 160 + h / 4] : 3'b000;
        end
        chk($sformatf("scan k=%0d", k),
            {28'd0, pix.ready, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B},
            {28'd0, (k >= CLR), (k % 2 == 1), hs, vs, bl, 1'b0, {10{c[2]}}, {10{c[1]}}, {10{c[0]}}});
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            k = 0;
            d1.v = 1'b0;
            d2.v = 1'b0;
            for (int i = 0; i < CLR; i++) fb[i] = 3'b000;
        end else if (k >= 0) begin
            k++;
            if (d2.v) fb[d2.a] = d2.c;
            d2 = d1;
            d1.v = (k >= CLR + 1) && pix.plot && (pix.x < 160) && (pix.y < 120);
            d1.a = int'(pix.y) * 160 + int'(pix.x);
            d1.c = pix.colour;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        pix.plot = 1'b0; pix.x = '0; pix.y = '0; pix.colour = '0;
    endtask

    task automatic put(input int px, input int py, input logic [2:0] c);
        pix.plot = 1'b1; pix.x = 10'(px); pix.y = 10'(py); pix.colour = c;
        tick();
        idle();
    endtask

    task automatic rand_plot();
        pix.plot   = ($urandom_range(0, 3) == 0);
        pix.x      = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(0, 17)) : 10'($urandom_range(150, 170));
        pix.y      = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(0, 13)) : 10'($urandom_range(115, 125));
        pix.colour = 3'($urandom);
    endtask

    int hs_low, vs_low, bl_high, r_on, g_on, b_on;

    initial begin
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // power-on clear, with one plot at clear cycle 100 that must be dropped
        while (k < CLR + 4) begin
            if (k == 99) put(5, 5, 3'b111);
            else tick();
        end

        // directed plots: two visible corners plus two out-of-range writes
        put(0, 0, 3'b100);
        put(15, 11, 3'b011);
        put(160, 0, 3'b111);
        put(0, 120, 3'b111);
        tick();
        tick();

        // one full frame, aggregate timing and colour coverage
        hs_low = 0; vs_low = 0; bl_high = 0; r_on = 0; g_on = 0; b_on = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            hs_low  += (VGA_HS == 1'b0);
            vs_low  += (VGA_VS == 1'b0);
            bl_high += (VGA_BLANK_N == 1'b1);
            r_on    += (VGA_R == 10'h3FF);
            g_on    += (VGA_G == 10'h3FF);
            b_on    += (VGA_B == 10'h3FF);
        end
        chk("hs_low_clk",  hs_low,  2 * HSY * VT);
        chk("vs_low_clk",  vs_low,  2 * VSY * HT);
        chk("blank_n_clk", bl_high, 2 * HV * VV);
        chk("red_clk",     r_on,    32);
        chk("green_clk",   g_on,    32);
        chk("blue_clk",    b_on,    32);

        // random plotting against the model
        for (int i = 0; i < 10000; i++) begin
            rand_plot();
            tick();
        end
        idle();

        // reset at line 30 of the shortened frame
        for (int i = 0; i < FRAME + 4; i++) begin
            if (((k - 2) / 2 / HT) % VT == 30) break;
            rand_plot();
            tick();
        end
        chk("line_before_reset", ((k - 2) / 2 / HT) % VT, 30);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ready_after_reset", pix.ready, 1'b0);

        // clear restarts; plots during it are ignored, later ones land
        while (k < CLR + 2000) begin
            rand_plot();
            tick();
        end
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
